// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage plus MEM/WB pipeline register.
//
// Handles loads and stores against an internal word-addressed data memory
// whose access latency is MEM_LAT cycles. While an access is still in
// flight, the stage stalls the upstream pipeline and loads bubbles into
// MEM/WB. It then registers the write-back bundle.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   WB[1:0]          {RegWrite, MemtoReg} from EX/MEM
//   M[1:0]           {MemRead, MemWrite} from EX/MEM (2'b11 acts as a store)
//   ALU_Result       byte address for memory ops, else the pass-through result
//   MemWriteData     store data
//   RdAddr           destination register
//   stall            combinational upstream hold request
//   WB_out, MemReadData, ALU_ResultOut, RdAddr_out   registered MEM/WB bundle
//   WriteBackData    MemtoReg ? MemReadData : ALU_ResultOut
module mem_wb_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB,
  input  logic [1:0]  M,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] MemWriteData,
  input  logic [4:0]  RdAddr,
  output logic        stall,
  output logic [1:0]  WB_out,
  output logic [31:0] MemReadData,
  output logic [31:0] ALU_ResultOut,
  output logic [4:0]  RdAddr_out,
  output logic [31:0] WriteBackData
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr;
  logic              is_mem;
  logic              is_store;
  logic              done;
  logic              mem_we;

  logic [3:0]  cnt_q,   cnt_d;
  logic [1:0]  wb_q,    wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q,   alu_d;
  logic [4:0]  rd_q,    rd_d;

  // Byte-offset bits and bits above the word address take no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALU_Result[31:ADDR_W+2], ALU_Result[1:0]};

  always_comb begin
    addr     = ALU_Result[ADDR_W+1:2];
    is_mem   = (M != 2'b00);
    is_store = M[0];
    done     = (cnt_q == CNT_LAST);
    stall    = rst_n && is_mem && !done;
    // The rst_n gate keeps a store from being written while reset is held.
    mem_we   = rst_n && is_mem && done && is_store;

    cnt_d   = '0;
    wb_d    = WB;
    rdata_d = '0;
    alu_d   = ALU_Result;
    rd_d    = RdAddr;

    if (is_mem && !done) begin
      cnt_d = cnt_q + 4'd1;
      wb_d  = '0;
      alu_d = '0;
      rd_d  = '0;
    end else if (is_mem && !is_store) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= MemWriteData;
  end

  assign WB_out        = wb_q;
  assign MemReadData   = rdata_q;
  assign ALU_ResultOut = alu_q;
  assign RdAddr_out    = rd_q;
  assign WriteBackData = wb_q[0] ? rdata_q : alu_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage. Four instances with MEM_LAT = 1..4 share the
// clock and reset. Instance k has MEM_LAT = k+1.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  wb_i  [4];
  logic [1:0]  m_i   [4];
  logic [31:0] alu_i [4];
  logic [31:0] wd_i  [4];
  logic [4:0]  rd_i  [4];
  logic        stall_o [4];
  logic [1:0]  wb_o    [4];
  logic [31:0] mrd_o   [4];
  logic [31:0] alu_o   [4];
  logic [4:0]  rd_o    [4];
  logic [31:0] wbd_o   [4];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_wb_stage #(.ADDR_W(8), .MEM_LAT(g + 1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .WB           (wb_i[g]),
      .M            (m_i[g]),
      .ALU_Result   (alu_i[g]),
      .MemWriteData (wd_i[g]),
      .RdAddr       (rd_i[g]),
      .stall        (stall_o[g]),
      .WB_out       (wb_o[g]),
      .MemReadData  (mrd_o[g]),
      .ALU_ResultOut(alu_o[g]),
      .RdAddr_out   (rd_o[g]),
      .WriteBackData(wbd_o[g])
    );
  end

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          stalls;
    logic [1:0]  e_wb;
    logic [31:0] e_mrd;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic [31:0] e_wbd;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [1:0] w, input logic [1:0] mm,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    wb_i[k] = w; m_i[k] = mm; alu_i[k] = a; wd_i[k] = d; rd_i[k] = r;
  endtask

  // Called just after a rising edge. Applies one instruction and counts
  // stall cycles and bubbles until the completion edge has passed.
  task automatic run_op(input int k, input logic [1:0] w, input logic [1:0] mm,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                        output int stalls, output int bubbles);
    bit fin;
    set_in(k, w, mm, a, d, r);
    stalls = 0; bubbles = 0; fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      #1;
      if (stall_o[k]) begin
        stalls++;
        @(posedge clk); #1;
        if (wb_o[k] == 2'b00 && mrd_o[k] == 32'd0 && alu_o[k] == 32'd0 && rd_o[k] == 5'd0)
          bubbles++;
      end else begin
        @(posedge clk); #1;
        fin = 1;
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d: stall still 1 after 20 cycles, required 0", k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, bb;

    // {wb, m, alu, wd, rd, stalls, e_wb, e_mrd, e_alu, e_rd, e_wbd}; MEM_LAT = 2
    vt[0] = '{2'b10, 2'b00, 32'h1234, 32'h0,        5'd5,  0, 2'b10, 32'h0,        32'h1234, 5'd5,  32'h1234};
    vt[1] = '{2'b00, 2'b01, 32'h10,   32'hDEADBEEF, 5'd0,  1, 2'b00, 32'h0,        32'h10,   5'd0,  32'h10};
    vt[2] = '{2'b11, 2'b10, 32'h10,   32'h0,        5'd8,  1, 2'b11, 32'hDEADBEEF, 32'h10,   5'd8,  32'hDEADBEEF};
    vt[3] = '{2'b00, 2'b11, 32'h400,  32'hA5A5A5A5, 5'd3,  1, 2'b00, 32'h0,        32'h400,  5'd3,  32'h400};
    vt[4] = '{2'b11, 2'b10, 32'h0,    32'h0,        5'd9,  1, 2'b11, 32'hA5A5A5A5, 32'h0,    5'd9,  32'hA5A5A5A5};
    vt[5] = '{2'b01, 2'b10, 32'h13,   32'h0,        5'd1,  1, 2'b01, 32'hDEADBEEF, 32'h13,   5'd1,  32'hDEADBEEF};
    vt[6] = '{2'b01, 2'b00, 32'hCAFE, 32'h0,        5'd31, 0, 2'b01, 32'h0,        32'hCAFE, 5'd31, 32'h0};
    vt[7] = '{2'b10, 2'b01, 32'h44,   32'h12345678, 5'd2,  1, 2'b10, 32'h0,        32'h44,   5'd2,  32'h44};
    vt[8] = '{2'b11, 2'b10, 32'h44,   32'h0,        5'd4,  1, 2'b11, 32'h12345678, 32'h44,   5'd4,  32'h12345678};

    // Reset held with a pending store on every instance
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) set_in(k, 2'b11, 2'b01, 32'hFFFF, 32'h1, 5'd31);
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst stall dut%0d", k), {31'd0, stall_o[k]}, 32'd0);
      chk($sformatf("rst wb dut%0d", k),    {30'd0, wb_o[k]},    32'd0);
      chk($sformatf("rst mrd dut%0d", k),   mrd_o[k],            32'd0);
      chk($sformatf("rst alu dut%0d", k),   alu_o[k],            32'd0);
      chk($sformatf("rst rd dut%0d", k),    {27'd0, rd_o[k]},    32'd0);
      chk($sformatf("rst wbd dut%0d", k),   wbd_o[k],            32'd0);
    end
    for (int k = 0; k < 4; k++) set_in(k, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven sequence on the MEM_LAT = 2 instance
    for (int i = 0; i < 9; i++) begin
      run_op(1, vt[i].wb, vt[i].m, vt[i].alu, vt[i].wd, vt[i].rd, st, bb);
      chk($sformatf("v%0d stalls", i),  st,                   vt[i].stalls);
      chk($sformatf("v%0d bubbles", i), bb,                   vt[i].stalls);
      chk($sformatf("v%0d wb", i),      {30'd0, wb_o[1]},     {30'd0, vt[i].e_wb});
      chk($sformatf("v%0d mrd", i),     mrd_o[1],             vt[i].e_mrd);
      chk($sformatf("v%0d alu", i),     alu_o[1],             vt[i].e_alu);
      chk($sformatf("v%0d rd", i),      {27'd0, rd_o[1]},     {27'd0, vt[i].e_rd});
      chk($sformatf("v%0d wbd", i),     wbd_o[1],             vt[i].e_wbd);
    end

    // Asynchronous reset between edges clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wb",  {30'd0, wb_o[1]}, 32'd0);
    chk("async rst mrd", mrd_o[1],         32'd0);
    chk("async rst alu", alu_o[1],         32'd0);
    chk("async rst rd",  {27'd0, rd_o[1]}, 32'd0);
    chk("async rst wbd", wbd_o[1],         32'd0);
    for (int k = 0; k < 4; k++) set_in(k, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency sweep: MEM_LAT = 1, 3, 4
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      run_op(k, 2'b00, 2'b01, 32'h10, 32'hA0000000 + k, 5'd0, st, bb);
      chk($sformatf("sweep%0d st stalls", k), st, k);
      run_op(k, 2'b11, 2'b10, 32'h10, 32'h0, 5'd7, st, bb);
      chk($sformatf("sweep%0d ld stalls", k),  st,               k);
      chk($sformatf("sweep%0d ld bubbles", k), bb,               k);
      chk($sformatf("sweep%0d ld mrd", k),     mrd_o[k],         32'hA0000000 + k);
      chk($sformatf("sweep%0d ld wb", k),      {30'd0, wb_o[k]}, 32'd3);
      chk($sformatf("sweep%0d ld rd", k),      {27'd0, rd_o[k]}, 32'd7);
      m_i[k] = 2'b00;
    end

    // Reset in the 2nd stall cycle of a store aborts it (MEM_LAT = 4)
    run_op(3, 2'b00, 2'b01, 32'h20, 32'h77, 5'd0, st, bb);
    chk("rstwait pre stalls", st, 3);
    set_in(3, 2'b00, 2'b01, 32'h20, 32'h55, 5'd0);
    #1;
    chk("rstwait stall c1", {31'd0, stall_o[3]}, 32'd1);
    @(posedge clk); #1;
    chk("rstwait stall c2", {31'd0, stall_o[3]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait stall drop", {31'd0, stall_o[3]}, 32'd0);
    m_i[3] = 2'b00;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3, 2'b11, 2'b10, 32'h20, 32'h0, 5'd6, st, bb);
    chk("rstwait ld stalls", st,       3);
    chk("rstwait ld mrd",    mrd_o[3], 32'h77);
    chk("rstwait ld wbd",    wbd_o[3], 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
